// File: rtl/bram_burst_reader_if.sv
// Bus bundle for the burst reader: request channel, RAM port, and output stream.
// The reader itself uses the slave view; the requester/RAM/consumer side uses the master view.
interface bram_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 10,
  parameter int LEN_WIDTH  = ADD_WIDTH + 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADD_WIDTH-1:0]  req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADD_WIDTH-1:0]  ram_add;
  logic [DATA_WIDTH-1:0] ram_data_out;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_addr, req_len, ram_data_out, m_ready,
    output req_ready, ram_cs, ram_we, ram_oe, ram_add,
    output m_valid, m_data, m_last, busy, done
  );

  modport master (
    output req_valid, req_addr, req_len, ram_data_out, m_ready,
    input  req_ready, ram_cs, ram_we, ram_oe, ram_add,
    input  m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst read controller for a single-port block RAM with one cycle of read latency.
// Read words land in a 2-entry FIFO; reads are only issued when a FIFO slot is guaranteed.
module bram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 10,
  parameter int LEN_WIDTH  = ADD_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bram_burst_reader_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ADD_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic                   done_q;

  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;

  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [2:0]             occupancy;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   head_last;

  // Slots already spoken for (stored + on the way from the RAM), net of this cycle's pop.
  assign pop       = (count_q != 2'd0) && bus.m_ready;
  assign push      = inflight_q;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == S_READ) && (remaining_q != '0) && (occupancy < 3'd2);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_q;
      logic                  last_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          last_q <= 1'b0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          data_q <= bus.ram_data_out;
          last_q <= inflight_last_q;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
  assign head_last = rd_ptr_q ? g_entry[1].last_q : g_entry[0].last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LEN_WIDTH'(1));

      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= bus.req_addr;
              remaining_q <= bus.req_len;
              state_q     <= S_READ;
            end
          end
        end

        S_READ: begin
          // Address wraps naturally at the top of the RAM.
          if (issue) begin
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (pop && head_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.ram_cs    = issue;
  assign bus.ram_oe    = issue;
  assign bus.ram_we    = 1'b0;
  assign bus.ram_add   = addr_q;
  assign bus.m_valid   = (count_q != 2'd0);
  assign bus.m_data    = (count_q != 2'd0) ? head_data : '0;
  assign bus.m_last    = (count_q != 2'd0) && head_last;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: a preloaded RAM model, a cycle monitor that logs
// issues/beats/done pulses, and a linear sequence of bursts checked against hand-computed values.
module tb_bram_burst_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_burst_reader_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  bram_burst_reader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [1 << AW];

  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_oe && !bus.ram_we) bus.ram_data_out <= mem[bus.ram_add];
  end

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int accept_cyc = 0;
  int accept_cnt = 0;
  int outstanding = 0;
  int ovf_viol = 0;
  int stab_viol = 0;
  int last_viol = 0;
  int oe_viol = 0;
  int valid_cycles = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  int            beat_cyc  [$];
  logic [AW-1:0] add_log   [$];
  int            done_cyc  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      outstanding <= 0;
      prev_hold   <= 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        accept_cyc <= cyc;
        accept_cnt <= accept_cnt + 1;
      end
      if (bus.ram_cs) begin
        add_log.push_back(bus.ram_add);
        if (!bus.ram_oe || bus.ram_we) oe_viol <= oe_viol + 1;
      end
      if (bus.m_valid) valid_cycles <= valid_cycles + 1;
      if (bus.m_last && !bus.m_valid) last_viol <= last_viol + 1;
      if (bus.m_valid && bus.m_ready) begin
        beat_data.push_back(bus.m_data);
        beat_last.push_back(bus.m_last);
        beat_cyc.push_back(cyc);
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (outstanding + int'(bus.ram_cs) - int'(bus.m_valid && bus.m_ready) > 2)
        ovf_viol <= ovf_viol + 1;
      outstanding <= outstanding + int'(bus.ram_cs) - int'(bus.m_valid && bus.m_ready);
      if (prev_hold && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stab_viol <= stab_viol + 1;
      prev_hold <= bus.m_valid && !bus.m_ready;
      prev_data <= bus.m_data;
      prev_last <= bus.m_last;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle; returns one cycle later (#1 after the edge).
  task automatic start_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n0;
    n0 = accept_cnt;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("req_accepted", accept_cnt - n0, 1);
    $display("request addr=0x%0h len=%0d accepted at cycle %0d", a, l, accept_cyc);
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd);
    int n;
    n = 0;
    while (done_cyc.size() == d0 && n < budget) begin
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("done_seen_in_budget", done_cyc.size() - d0, 1);
  endtask

  initial begin
    int a_c, b0, a0, d0, v0, s0, mism, lasts;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.m_ready   = 1'b1;

    // Reset values
    #12;
    check1("rst_req_ready", bus.req_ready, 1'b1);
    check1("rst_ram_cs", bus.ram_cs, 1'b0);
    check1("rst_ram_oe", bus.ram_oe, 1'b0);
    check1("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_add", 32'(bus.ram_add), 0);
    check1("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_data", bus.m_data, 0);
    check1("rst_m_last", bus.m_last, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Burst addr=4 len=4, consumer always ready
    b0 = beat_data.size(); d0 = done_cyc.size();
    start_req(10'h004, 11'd4);
    a_c = accept_cyc;
    check1("t1_busy", bus.busy, 1'b1);
    check1("t1_req_ready_low", bus.req_ready, 1'b0);
    wait_done(d0, 40, 1'b0);
    check("t1_beats", beat_data.size() - b0, 4);
    for (int i = 0; i < 4 && b0 + i < beat_data.size(); i++) begin
      check($sformatf("t1_data%0d", i), beat_data[b0+i], 32'h104 + i);
      check1($sformatf("t1_last%0d", i), beat_last[b0+i], (i == 3));
      check($sformatf("t1_cyc%0d", i), beat_cyc[b0+i] - a_c, 3 + i);
      $display("t1 beat %0d data=0x%0h last=%b", i, beat_data[b0+i], beat_last[b0+i]);
    end
    check("t1_done_cycle", done_cyc[done_cyc.size()-1] - a_c, 7);

    // Same burst, consumer stalled for cycles 0..8 after the accept
    b0 = beat_data.size(); a0 = add_log.size(); d0 = done_cyc.size(); s0 = stab_viol;
    bus.m_ready = 1'b0;
    start_req(10'h004, 11'd4);
    a_c = accept_cyc;
    repeat (8) begin @(posedge clk); #1; end
    check("t2_issues_while_stalled", add_log.size() - a0, 2);
    check1("t2_m_valid_stalled", bus.m_valid, 1'b1);
    check1("t2_ram_cs_fifo_full", bus.ram_cs, 1'b0);
    check("t2_head_while_stalled", bus.m_data, 32'h104);
    bus.m_ready = 1'b1;
    wait_done(d0, 40, 1'b0);
    check("t2_beats", beat_data.size() - b0, 4);
    check("t2_issues", add_log.size() - a0, 4);
    for (int i = 0; i < 4 && b0 + i < beat_data.size(); i++) begin
      check($sformatf("t2_data%0d", i), beat_data[b0+i], 32'h104 + i);
      check1($sformatf("t2_last%0d", i), beat_last[b0+i], (i == 3));
      check($sformatf("t2_cyc%0d", i), beat_cyc[b0+i] - a_c, 9 + i);
      $display("t2 beat %0d data=0x%0h last=%b", i, beat_data[b0+i], beat_last[b0+i]);
    end
    for (int i = 0; i < 4 && a0 + i < add_log.size(); i++)
      check($sformatf("t2_add%0d", i), 32'(add_log[a0+i]), 32'h004 + i);
    check("t2_done_cycle", done_cyc[done_cyc.size()-1] - a_c, 13);
    check("t2_stable_viol", stab_viol - s0, 0);

    // Address wrap at the top of the RAM
    b0 = beat_data.size(); a0 = add_log.size(); d0 = done_cyc.size();
    start_req(10'h3FE, 11'd4);
    wait_done(d0, 40, 1'b0);
    check("t3_issues", add_log.size() - a0, 4);
    if (add_log.size() - a0 == 4) begin
      check("t3_add0", 32'(add_log[a0+0]), 32'h3FE);
      check("t3_add1", 32'(add_log[a0+1]), 32'h3FF);
      check("t3_add2", 32'(add_log[a0+2]), 32'h000);
      check("t3_add3", 32'(add_log[a0+3]), 32'h001);
    end
    check("t3_beats", beat_data.size() - b0, 4);
    if (beat_data.size() - b0 == 4) begin
      check("t3_data0", beat_data[b0+0], 32'h4FE);
      check("t3_data1", beat_data[b0+1], 32'h4FF);
      check("t3_data2", beat_data[b0+2], 32'h100);
      check("t3_data3", beat_data[b0+3], 32'h101);
      check1("t3_last2", beat_last[b0+2], 1'b0);
      check1("t3_last3", beat_last[b0+3], 1'b1);
      for (int i = 0; i < 4; i++) $display("t3 beat %0d data=0x%0h last=%b", i, beat_data[b0+i], beat_last[b0+i]);
    end

    // Zero-length request
    a0 = add_log.size(); d0 = done_cyc.size(); v0 = valid_cycles;
    check1("t4_req_ready_before", bus.req_ready, 1'b1);
    start_req(10'h010, 11'd0);
    a_c = accept_cyc;
    check1("t4_done_pulse", bus.done, 1'b1);
    check1("t4_req_ready_after", bus.req_ready, 1'b1);
    check1("t4_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check1("t4_done_cleared", bus.done, 1'b0);
    check1("t4_req_ready_later", bus.req_ready, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_done_count", done_cyc.size() - d0, 1);
    if (done_cyc.size() > d0) check("t4_done_cycle", done_cyc[d0] - a_c, 1);
    check("t4_no_ram_access", add_log.size() - a0, 0);
    check("t4_no_m_valid", valid_cycles - v0, 0);
    $display("t4 zero-length request: done count=%0d", done_cyc.size() - d0);

    // Reset in the middle of an 8-beat burst
    b0 = beat_data.size();
    start_req(10'h000, 11'd8);
    for (int n = 0; n < 20 && beat_data.size() - b0 < 2; n++) begin @(posedge clk); #1; end
    check("t5_beats_before_reset", beat_data.size() - b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check1("t5_req_ready", bus.req_ready, 1'b1);
    check1("t5_ram_cs", bus.ram_cs, 1'b0);
    check1("t5_ram_oe", bus.ram_oe, 1'b0);
    check1("t5_ram_we", bus.ram_we, 1'b0);
    check("t5_ram_add", 32'(bus.ram_add), 0);
    check1("t5_m_valid", bus.m_valid, 1'b0);
    check("t5_m_data", bus.m_data, 0);
    check1("t5_m_last", bus.m_last, 1'b0);
    check1("t5_busy", bus.busy, 1'b0);
    check1("t5_done", bus.done, 1'b0);
    b0 = beat_data.size(); d0 = done_cyc.size(); v0 = valid_cycles;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_no_stale_valid", valid_cycles - v0, 0);
    check("t5_no_done_after_reset", done_cyc.size() - d0, 0);
    start_req(10'h000, 11'd1);
    wait_done(d0, 40, 1'b0);
    check("t5_beats_after", beat_data.size() - b0, 1);
    if (beat_data.size() > b0) begin
      check("t5_data", beat_data[b0], 32'h100);
      check1("t5_last", beat_last[b0], 1'b1);
      $display("t5 post-reset beat data=0x%0h last=%b", beat_data[b0], beat_last[b0]);
    end

    // Full-depth burst with random backpressure
    b0 = beat_data.size(); d0 = done_cyc.size();
    start_req(10'h000, 11'd1024);
    wait_done(d0, 8000, 1'b1);
    bus.m_ready = 1'b1;
    check("t6_beats", beat_data.size() - b0, 1024);
    mism = 0;
    lasts = 0;
    for (int i = 0; b0 + i < beat_data.size(); i++) begin
      if (beat_data[b0+i] !== 32'h100 + i) mism++;
      if (beat_last[b0+i]) lasts++;
    end
    check("t6_data_mismatches", mism, 0);
    check("t6_last_count", lasts, 1);
    if (beat_data.size() > b0) check1("t6_last_on_final", beat_last[beat_data.size()-1], 1'b1);
    $display("t6 full burst: beats=%0d last flags=%0d mismatches=%0d", beat_data.size() - b0, lasts, mism);

    check("fifo_overflow", ovf_viol, 0);
    check("stream_stability", stab_viol, 0);
    check("last_without_valid", last_viol, 0);
    check("ram_strobes", oe_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "global timeout");
  end
endmodule
